i2c_byte_shifter: RTL
=====================

# i2c_byte_shifter

Parametrised, clocked shift datapath for the I2C master core. Under control of the master FSM it serialises one address or data frame onto SDA, or deserialises one data frame from SDA. It also handles the ninth (ACK) bit in both directions. It keeps its own bit counter and shift register, so the FSM only issues a start command plus SCL-phase strobes (one-cycle pulses marking each SCL edge) and reacts to completion pulses.

## Interface
- DATA_SIZE, 8, data frame length in bits (≥2)
- ADDR_SIZE, 7, slave address width; address frame = {addr, rw}, ADDR_SIZE+1 bits
- Internal shift width W = max(DATA_SIZE, ADDR_SIZE+1); counter width = $clog2(W)

Ports:
- i2c_core_clk_i  in  1  core clock (one clock domain)
- reset_i  in  1  asynchronous, active-high reset
- start_tx_i  in  1  pulse: load and begin a transmit frame
- tx_addr_i  in  1  qualifies start_tx_i: 1 = address frame, 0 = data frame
- addr_i  in  ADDR_SIZE  slave address
- rw_i  in  1  R/W bit appended after the address
- data_i  in  DATA_SIZE  transmit data
- start_rx_i  in  1  pulse: begin a receive frame
- ack_en_i  in  1  receive only: 1 = master drives ACK (0), 0 = NACK (released)
- scl_fall_i  in  1  pulse: SCL falling edge (drive phase)
- scl_rise_i  in  1  pulse: SCL rising edge (sample phase)
- abort_i  in  1  synchronous abort to IDLE
- sda_low_en_i  in  1  forces i2c_sda_o low (START/STOP generation); combinational override
- i2c_sda_i  in  1  sampled SDA line
- i2c_sda_o  out  1  SDA drive; 1 = release, 0 = pull low
- data_from_sda_o  out  DATA_SIZE  last received byte, held until next receive completes
- rx_valid_o  out  1  one-cycle pulse when data_from_sda_o updates
- ack_o  out  1  ACK bit sampled from the slave (0 = ACK, 1 = NACK)
- frame_done_o  out  1  one-cycle pulse at end of frame including ACK bit
- busy_o  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, TX_BIT, TX_ACK, RX_BIT, RX_ACK_DRV, RX_ACK_HOLD.
- Load rules:
  - On start_tx_i in IDLE, the shift register loads the frame MSB-aligned:
    - Address frame: {addr_i, rw_i}, N = ADDR_SIZE+1.
    - Data frame: data_i, N = DATA_SIZE.
  - The counter loads N-1, sda_q takes the frame MSB, and the state goes to TX_BIT.
- TX_BIT, on scl_fall_i:
  - If cnt == 0: sda_q = 1 (release) and the state goes to TX_ACK.
  - Otherwise: shift left, cnt−1, and sda_q takes the next bit.
- TX_ACK, on scl_rise_i: ack_o ← i2c_sda_i, frame_done_o pulses, and the state goes to IDLE.
- Receive start: on start_rx_i in IDLE, sda_q = 1, cnt = DATA_SIZE−1, and the state goes to RX_BIT.
- RX_BIT, on scl_rise_i:
  - The shift register takes {shift[DATA_SIZE−2:0], i2c_sda_i} (MSB first).
  - If cnt == 0, the state goes to RX_ACK_DRV; otherwise cnt−1.
- RX_ACK_DRV, on scl_fall_i:
  - sda_q = ~ack_en_i, and data_from_sda_o ← shift register.
  - rx_valid_o pulses and the state goes to RX_ACK_HOLD.
- RX_ACK_HOLD, on scl_fall_i: sda_q = 1, frame_done_o pulses, and the state goes to IDLE.
- Output: i2c_sda_o = sda_low_en_i ? 0 : sda_q. sda_low_en_i never alters state or counter.
- Boundary conditions:
  - start_tx_i and start_rx_i are ignored when not in IDLE.
  - start_tx_i and start_rx_i in the same cycle: transmit wins.
  - scl_rise_i and scl_fall_i in the same cycle: both are ignored and state is held.
  - abort_i, from any state, gives IDLE and sda_q = 1 next cycle. It produces no frame_done_o or rx_valid_o. data_from_sda_o and ack_o are kept.
  - Strobes arriving in IDLE are ignored.

## Timing
- All outputs except the sda_low_en_i override are registered. They update on the i2c_core_clk_i edge at which the qualifying start or strobe is sampled high.
- The first transmit bit appears on i2c_sda_o 1 cycle after start_tx_i.
- Each subsequent bit appears 1 cycle after its scl_fall_i.
- Latency, in SCL strobes:
  - Transmit: N scl_fall_i + 1 scl_rise_i, start to frame_done_o.
  - Receive: DATA_SIZE scl_rise_i + 2 scl_fall_i.
- rx_valid_o and frame_done_o are single-cycle and never asserted in the same cycle.
- busy_o rises 1 cycle after start and falls in the same cycle frame_done_o is high.
- Reset values (asynchronous, while reset_i is high):
  - State IDLE, sda_q = 1, i2c_sda_o = 1 (unless sda_low_en_i).
  - data_from_sda_o = 0, ack_o = 0, rx_valid_o = 0, frame_done_o = 0, busy_o = 0, counter = 0.
  - Reset mid-frame discards the frame with no pulses.

## Test plan
- Address frame: addr_i = 7'h50, rw_i = 0, 8 falls → i2c_sda_o sequence 1,0,1,0,0,0,0,0. Slave drives 0 at the ninth rise → ack_o = 0, one frame_done_o, busy_o low.
- Data receive: slave drives 0xA5 MSB first, ack_en_i = 1 → data_from_sda_o = 8'hA5 with rx_valid_o after the 9th fall. i2c_sda_o = 0 during the ACK bit, released after the 10th fall.
- Receive with ack_en_i = 0, slave drives 0xFF → data_from_sda_o = 8'hFF; i2c_sda_o stays 1 throughout.
- DATA_SIZE = 16, ADDR_SIZE = 10, data_i = 16'h8001 → 16 bits on SDA (1, fourteen 0s, 1). Slave NACK → ack_o = 1.
- Robustness:
  - abort_i after 3 transmit bits → IDLE next cycle, i2c_sda_o = 1, no frame_done_o.
  - reset_i pulsed mid-receive → all reset values at once.
  - sda_low_en_i = 1 during TX_BIT → i2c_sda_o = 0 while the counter is unchanged.
- Simultaneous start_tx_i and start_rx_i → transmit frame. start_tx_i while busy_o is high → ignored, frame continues unchanged. Simultaneous rise and fall strobes → no state change.

Source files
------------

// File: rtl/i2c_byte_shifter_if.sv
// Control/data bundle between the I2C master FSM and the byte shifter.
interface i2c_byte_shifter_if #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned ADDR_SIZE = 7
);
  logic                 start_tx_i;
  logic                 tx_addr_i;
  logic [ADDR_SIZE-1:0] addr_i;
  logic                 rw_i;
  logic [DATA_SIZE-1:0] data_i;
  logic                 start_rx_i;
  logic                 ack_en_i;
  logic                 scl_fall_i;
  logic                 scl_rise_i;
  logic                 abort_i;
  logic                 sda_low_en_i;
  logic                 i2c_sda_i;
  logic                 i2c_sda_o;
  logic [DATA_SIZE-1:0] data_from_sda_o;
  logic                 rx_valid_o;
  logic                 ack_o;
  logic                 frame_done_o;
  logic                 busy_o;

  // FSM side: issues commands and strobes, consumes results.
  modport master (
    output start_tx_i, tx_addr_i, addr_i, rw_i, data_i, start_rx_i, ack_en_i,
           scl_fall_i, scl_rise_i, abort_i, sda_low_en_i, i2c_sda_i,
    input  i2c_sda_o, data_from_sda_o, rx_valid_o, ack_o, frame_done_o, busy_o
  );

  // Shifter side.
  modport slave (
    input  start_tx_i, tx_addr_i, addr_i, rw_i, data_i, start_rx_i, ack_en_i,
           scl_fall_i, scl_rise_i, abort_i, sda_low_en_i, i2c_sda_i,
    output i2c_sda_o, data_from_sda_o, rx_valid_o, ack_o, frame_done_o, busy_o
  );
endinterface

// File: rtl/i2c_byte_shifter.sv
// I2C frame shifter: serialises address/data frames onto SDA, deserialises
// received bytes, and handles the ninth (ACK) bit in both directions.
module i2c_byte_shifter #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned ADDR_SIZE = 7
) (
  input  logic          i2c_core_clk_i,
  input  logic          reset_i,
  i2c_byte_shifter_if.slave bus
);

  localparam int unsigned FW = ADDR_SIZE + 1;
  localparam int unsigned W  = (DATA_SIZE > FW) ? DATA_SIZE : FW;
  localparam int unsigned CW = $clog2(W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_BIT,
    S_TX_ACK,
    S_RX_BIT,
    S_RX_ACK_DRV,
    S_RX_ACK_HOLD
  } state_t;

  state_t               r_state, r_state_n;
  logic [W-1:0]         r_shift, r_shift_n;
  logic [CW-1:0]        r_cnt, r_cnt_n;
  logic                 r_sda, r_sda_n;
  logic [DATA_SIZE-1:0] r_data, r_data_n;
  logic                 r_rx_valid, r_rx_valid_n;
  logic                 r_ack, r_ack_n;
  logic                 r_done, r_done_n;
  logic                 r_busy, r_busy_n;

  logic                 w_rise;
  logic                 w_fall;
  logic [W-1:0]         w_addr_frame;
  logic [W-1:0]         w_data_frame;

  // Coincident SCL strobes are contradictory; treat both as absent.
  assign w_rise = bus.scl_rise_i & ~bus.scl_fall_i;
  assign w_fall = bus.scl_fall_i & ~bus.scl_rise_i;

  // Frames are MSB-aligned in the shift register so TX always reads bit W-1.
  assign w_addr_frame = W'({bus.addr_i, bus.rw_i}) << (W - FW);
  assign w_data_frame = W'(bus.data_i) << (W - DATA_SIZE);

  // State and datapath registers.
  always_ff @(posedge i2c_core_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_sda      <= 1'b1;
      r_data     <= '0;
      r_rx_valid <= 1'b0;
      r_ack      <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= r_state_n;
      r_shift    <= r_shift_n;
      r_cnt      <= r_cnt_n;
      r_sda      <= r_sda_n;
      r_data     <= r_data_n;
      r_rx_valid <= r_rx_valid_n;
      r_ack      <= r_ack_n;
      r_done     <= r_done_n;
      r_busy     <= r_busy_n;
    end
  end

  // Next-state and datapath update; abort overrides everything.
  always_comb begin
    r_state_n    = r_state;
    r_shift_n    = r_shift;
    r_cnt_n      = r_cnt;
    r_sda_n      = r_sda;
    r_data_n     = r_data;
    r_ack_n      = r_ack;
    r_rx_valid_n = 1'b0;
    r_done_n     = 1'b0;

    if (bus.abort_i) begin
      r_state_n = S_IDLE;
      r_sda_n   = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_tx_i) begin
            r_state_n = S_TX_BIT;
            if (bus.tx_addr_i) begin
              r_shift_n = w_addr_frame;
              r_cnt_n   = CW'(FW - 1);
              r_sda_n   = bus.addr_i[ADDR_SIZE-1];
            end else begin
              r_shift_n = w_data_frame;
              r_cnt_n   = CW'(DATA_SIZE - 1);
              r_sda_n   = bus.data_i[DATA_SIZE-1];
            end
          end else if (bus.start_rx_i) begin
            r_state_n = S_RX_BIT;
            r_sda_n   = 1'b1;
            r_cnt_n   = CW'(DATA_SIZE - 1);
          end
        end
        S_TX_BIT: begin
          if (w_fall) begin
            if (r_cnt == '0) begin
              r_sda_n   = 1'b1;
              r_state_n = S_TX_ACK;
            end else begin
              r_shift_n = r_shift << 1;
              r_cnt_n   = r_cnt - CW'(1);
              r_sda_n   = r_shift[W-2];
            end
          end
        end
        S_TX_ACK: begin
          if (w_rise) begin
            r_ack_n   = bus.i2c_sda_i;
            r_done_n  = 1'b1;
            r_state_n = S_IDLE;
          end
        end
        S_RX_BIT: begin
          if (w_rise) begin
            r_shift_n[DATA_SIZE-1:0] = {r_shift[DATA_SIZE-2:0], bus.i2c_sda_i};
            if (r_cnt == '0) begin
              r_state_n = S_RX_ACK_DRV;
            end else begin
              r_cnt_n = r_cnt - CW'(1);
            end
          end
        end
        S_RX_ACK_DRV: begin
          if (w_fall) begin
            r_sda_n      = ~bus.ack_en_i;
            r_data_n     = r_shift[DATA_SIZE-1:0];
            r_rx_valid_n = 1'b1;
            r_state_n    = S_RX_ACK_HOLD;
          end
        end
        S_RX_ACK_HOLD: begin
          if (w_fall) begin
            r_sda_n   = 1'b1;
            r_done_n  = 1'b1;
            r_state_n = S_IDLE;
          end
        end
        default: begin
          r_state_n = S_IDLE;
          r_sda_n   = 1'b1;
        end
      endcase
    end

    r_busy_n = (r_state_n != S_IDLE);
  end

  // START/STOP generation may pull SDA low without disturbing the shifter.
  assign bus.i2c_sda_o       = bus.sda_low_en_i ? 1'b0 : r_sda;
  assign bus.data_from_sda_o = r_data;
  assign bus.rx_valid_o      = r_rx_valid;
  assign bus.ack_o           = r_ack;
  assign bus.frame_done_o    = r_done;
  assign bus.busy_o          = r_busy;

endmodule
